// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage_if
// Purpose  : Memory-to-writeback stage bus: stage inputs, writeback port, bypass.
// Revision : 1.0
// ============================================================================
interface mem_wb_stage_if;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_rf_we;
    logic [4:0]  in_wr;
    logic [1:0]  in_wd_sel;
    logic [31:0] in_alu_res;
    logic [31:0] in_pc4;
    logic [31:0] in_imm;
    logic [31:0] in_dram_rdata;
    logic [2:0]  in_load_type;
    logic [4:0]  rR1;
    logic [4:0]  rR2;
    logic [31:0] rD1_rf;
    logic [31:0] rD2_rf;
    logic        WE;
    logic [4:0]  wR;
    logic [31:0] WD;
    logic [31:0] rD1_fwd;
    logic [31:0] rD2_fwd;
    logic        wb_valid;
    logic        misalign;
    logic [31:0] instret;

    modport master (
        output stall, flush, in_valid, in_rf_we, in_wr, in_wd_sel, in_alu_res,
               in_pc4, in_imm, in_dram_rdata, in_load_type, rR1, rR2, rD1_rf, rD2_rf,
        input  WE, wR, WD, rD1_fwd, rD2_fwd, wb_valid, misalign, instret
    );

    modport slave (
        input  stall, flush, in_valid, in_rf_we, in_wr, in_wd_sel, in_alu_res,
               in_pc4, in_imm, in_dram_rdata, in_load_type, rR1, rR2, rD1_rf, rD2_rf,
        output WE, wR, WD, rD1_fwd, rD2_fwd, wb_valid, misalign, instret
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM/WB pipeline register, load extraction, writeback mux, bypass.
// Revision : 1.0
// ============================================================================
module mem_wb_stage (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
);
    localparam logic [1:0] c_SEL_ALU  = 2'b00;
    localparam logic [1:0] c_SEL_LOAD = 2'b01;
    localparam logic [1:0] c_SEL_PC4  = 2'b10;
    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LW  = 3'b010;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;

    logic        valid_q,     valid_d;
    logic        rf_we_q,     rf_we_d;
    logic [4:0]  wr_q,        wr_d;
    logic [1:0]  wd_sel_q,    wd_sel_d;
    logic [31:0] alu_res_q,   alu_res_d;
    logic [31:0] pc4_q,       pc4_d;
    logic [31:0] imm_q,       imm_d;
    logic [31:0] rdata_q,     rdata_d;
    logic [2:0]  load_type_q, load_type_d;
    logic [31:0] instret_q,   instret_d;

    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_misalign;
    logic        w_we;
    logic [31:0] w_wd;

    // Flush only invalidates the slot; the remaining fields are left as-is.
    always_comb begin
        valid_d     = valid_q;
        rf_we_d     = rf_we_q;
        wr_d        = wr_q;
        wd_sel_d    = wd_sel_q;
        alu_res_d   = alu_res_q;
        pc4_d       = pc4_q;
        imm_d       = imm_q;
        rdata_d     = rdata_q;
        load_type_d = load_type_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            valid_d     = bus.in_valid;
            rf_we_d     = bus.in_rf_we;
            wr_d        = bus.in_wr;
            wd_sel_d    = bus.in_wd_sel;
            alu_res_d   = bus.in_alu_res;
            pc4_d       = bus.in_pc4;
            imm_d       = bus.in_imm;
            rdata_d     = bus.in_dram_rdata;
            load_type_d = bus.in_load_type;
        end
    end

    // Retirement is the held instruction leaving, so flush does not suppress it.
    always_comb begin
        instret_d = instret_q;
        if (valid_q && !bus.stall) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rf_we_q     <= 1'b0;
            wr_q        <= 5'd0;
            wd_sel_q    <= 2'b00;
            alu_res_q   <= 32'd0;
            pc4_q       <= 32'd0;
            imm_q       <= 32'd0;
            rdata_q     <= 32'd0;
            load_type_q <= 3'b000;
            instret_q   <= 32'd0;
        end else begin
            valid_q     <= valid_d;
            rf_we_q     <= rf_we_d;
            wr_q        <= wr_d;
            wd_sel_q    <= wd_sel_d;
            alu_res_q   <= alu_res_d;
            pc4_q       <= pc4_d;
            imm_q       <= imm_d;
            rdata_q     <= rdata_d;
            load_type_q <= load_type_d;
            instret_q   <= instret_d;
        end
    end

    always_comb begin
        w_off  = alu_res_q[1:0];
        w_byte = rdata_q[{w_off, 3'b000} +: 8];
        w_half = w_off[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (load_type_q)
            c_LB:    w_load = {{24{w_byte[7]}}, w_byte};
            c_LBU:   w_load = {24'd0, w_byte};
            c_LH:    w_load = {{16{w_half[15]}}, w_half};
            c_LHU:   w_load = {16'd0, w_half};
            default: w_load = rdata_q;
        endcase
    end

    always_comb begin
        w_misalign = valid_q && (wd_sel_q == c_SEL_LOAD) &&
                     ((((load_type_q == c_LH) || (load_type_q == c_LHU)) && w_off[0]) ||
                      ((load_type_q == c_LW) && (w_off != 2'b00)));
        case (wd_sel_q)
            c_SEL_ALU:  w_wd = alu_res_q;
            c_SEL_LOAD: w_wd = w_misalign ? rdata_q : w_load;
            c_SEL_PC4:  w_wd = pc4_q;
            default:    w_wd = imm_q;
        endcase
        w_we = valid_q && rf_we_q && (wr_q != 5'd0) && !w_misalign;
    end

    assign bus.WE       = w_we;
    assign bus.wR       = wr_q;
    assign bus.WD       = w_wd;
    assign bus.wb_valid = valid_q;
    assign bus.misalign = w_misalign;
    assign bus.instret  = instret_q;
    // w_we already excludes x0, so a zero read index always sees the raw file.
    assign bus.rD1_fwd  = (w_we && (wr_q == bus.rR1)) ? w_wd : bus.rD1_rf;
    assign bus.rD2_fwd  = (w_we && (wr_q == bus.rR2)) ? w_wd : bus.rD2_rf;
endmodule
`default_nettype wire
